// File: rtl/pb_eject_error_sink.sv
// pb_eject_error_sink: terminates the Eject port of a dummy NoC tile router.
// It takes every ejected AW/W/AR flit and answers each AXI transaction with
// an error response (a single B, or an R burst of zero data). Stray traffic
// to an unpopulated tile therefore completes and does not stall the mesh.
// Optional build macro: PB_EJECT_ERR_CNT_EN adds a saturating count of
// completed error transactions and the source node of the most recent one.
module pb_eject_error_sink #(
  parameter int          IdWidth   = 4,
  parameter int          NodeIdW   = 6,
  parameter int          DataWidth = 64,
  parameter logic [1:0]  RespCode  = 2'b11
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [1:0]           req_type_i,
  input  logic [IdWidth-1:0]   req_axi_id_i,
  input  logic [NodeIdW-1:0]   req_src_id_i,
  input  logic [7:0]           req_len_i,
  input  logic                 req_last_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_type_o,
  output logic [IdWidth-1:0]   rsp_axi_id_o,
  output logic [NodeIdW-1:0]   rsp_dst_id_o,
  output logic [1:0]           rsp_resp_o,
  output logic                 rsp_last_o,
  output logic [DataWidth-1:0] rsp_data_o,
  output logic                 orphan_w_o
`ifdef PB_EJECT_ERR_CNT_EN
  ,
  output logic [15:0]          err_cnt_o,
  output logic [NodeIdW-1:0]   last_src_o
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    W_DRAIN = 2'd1,
    B_SEND  = 2'd2,
    R_SEND  = 2'd3
  } state_t;

  localparam logic [1:0] TypeAw = 2'd0;
  localparam logic [1:0] TypeW  = 2'd1;
  localparam logic [1:0] TypeAr = 2'd2;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_alive;
  logic                 w_ready;
  logic                 w_req_accept;
  logic                 w_rsp_hs;
  logic [7:0]           r_len;
  logic [7:0]           r_beat;
  logic                 r_rsp_valid;
  logic                 r_rsp_type;
  logic [IdWidth-1:0]   r_rsp_axi_id;
  logic [NodeIdW-1:0]   r_rsp_dst_id;
  logic [1:0]           r_rsp_resp;
  logic                 r_rsp_last;
  logic                 r_orphan_w;

  // Holds req_ready low until the first clock edge after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_alive <= 1'b0;
    else         r_alive <= 1'b1;
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state and request-ready decode; only one transaction is ever open.
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = r_alive;
        if (r_alive && req_valid_i) begin
          if (req_type_i == TypeAw)      w_state_next = W_DRAIN;
          else if (req_type_i == TypeAr) w_state_next = R_SEND;
        end
      end
      W_DRAIN: begin
        w_ready = (req_type_i == TypeW);
        if (req_valid_i && (req_type_i == TypeW) && req_last_i) w_state_next = B_SEND;
      end
      B_SEND: begin
        if (rsp_ready_i) w_state_next = IDLE;
      end
      R_SEND: begin
        if (rsp_ready_i && r_rsp_last) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_req_accept = req_valid_i & w_ready;
  assign w_rsp_hs     = r_rsp_valid & rsp_ready_i;

  // Response registers: loaded when a transaction opens, advanced per R beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_type   <= 1'b0;
      r_rsp_axi_id <= '0;
      r_rsp_dst_id <= '0;
      r_rsp_resp   <= 2'b00;
      r_rsp_last   <= 1'b0;
      r_len        <= 8'd0;
      r_beat       <= 8'd0;
      r_orphan_w   <= 1'b0;
    end else begin
      r_rsp_valid <= (w_state_next == B_SEND) || (w_state_next == R_SEND);
      if ((r_state == IDLE) && w_req_accept) begin
        if (req_type_i == TypeAw) begin
          r_rsp_axi_id <= req_axi_id_i;
          r_rsp_dst_id <= req_src_id_i;
        end else if (req_type_i == TypeAr) begin
          r_rsp_axi_id <= req_axi_id_i;
          r_rsp_dst_id <= req_src_id_i;
          r_len        <= req_len_i;
          r_beat       <= 8'd0;
          r_rsp_type   <= 1'b1;
          r_rsp_resp   <= RespCode;
          r_rsp_last   <= (req_len_i == 8'd0);
        end else if (req_type_i == TypeW) begin
          r_orphan_w   <= 1'b1;
        end
      end
      if ((r_state == W_DRAIN) && w_req_accept && req_last_i) begin
        r_rsp_type <= 1'b0;
        r_rsp_resp <= RespCode;
        r_rsp_last <= 1'b1;
      end
      if ((r_state == R_SEND) && w_rsp_hs && !r_rsp_last) begin
        r_beat     <= r_beat + 8'd1;
        r_rsp_last <= ((r_beat + 8'd1) == r_len);
      end
    end
  end

  assign req_ready_o  = w_ready;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_type_o   = r_rsp_type;
  assign rsp_axi_id_o = r_rsp_axi_id;
  assign rsp_dst_id_o = r_rsp_dst_id;
  assign rsp_resp_o   = r_rsp_resp;
  assign rsp_last_o   = r_rsp_last;
  assign rsp_data_o   = '0;
  assign orphan_w_o   = r_orphan_w;

`ifdef PB_EJECT_ERR_CNT_EN
  logic [15:0]        r_err_cnt;
  logic [NodeIdW-1:0] r_last_src;
  logic               w_done;

  assign w_done = w_rsp_hs & r_rsp_last;

  // Counts completed error transactions (saturating) and records their source.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_cnt  <= 16'd0;
      r_last_src <= '0;
    end else if (w_done) begin
      if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
      r_last_src <= r_rsp_dst_id;
    end
  end

  assign err_cnt_o  = r_err_cnt;
  assign last_src_o = r_last_src;
`endif

endmodule

// File: tb/tb_pb_eject_error_sink.sv
// Directed self-checking bench for pb_eject_error_sink.
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
module tb_pb_eject_error_sink;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_type_i;
  logic [3:0]  req_axi_id_i;
  logic [5:0]  req_src_id_i;
  logic [7:0]  req_len_i;
  logic        req_last_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic        rsp_type_o;
  logic [3:0]  rsp_axi_id_o;
  logic [5:0]  rsp_dst_id_o;
  logic [1:0]  rsp_resp_o;
  logic        rsp_last_o;
  logic [63:0] rsp_data_o;
  logic        orphan_w_o;
`ifdef PB_EJECT_ERR_CNT_EN
  logic [15:0] err_cnt_o;
  logic [5:0]  last_src_o;
`endif

  int checks = 0;
  int errors = 0;

  pb_eject_error_sink dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_type_i   (req_type_i),
    .req_axi_id_i (req_axi_id_i),
    .req_src_id_i (req_src_id_i),
    .req_len_i    (req_len_i),
    .req_last_i   (req_last_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_type_o   (rsp_type_o),
    .rsp_axi_id_o (rsp_axi_id_o),
    .rsp_dst_id_o (rsp_dst_id_o),
    .rsp_resp_o   (rsp_resp_o),
    .rsp_last_o   (rsp_last_o),
    .rsp_data_o   (rsp_data_o),
    .orphan_w_o   (orphan_w_o)
`ifdef PB_EJECT_ERR_CNT_EN
    ,
    .err_cnt_o    (err_cnt_o),
    .last_src_o   (last_src_o)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk_i = ~clk_i;

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] t, input logic [3:0] id,
                               input logic [5:0] src, input logic [7:0] len, input logic last);
    req_valid_i  = v;
    req_type_i   = t;
    req_axi_id_i = id;
    req_src_id_i = src;
    req_len_i    = len;
    req_last_i   = last;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_ni      = 1'b0;
    rsp_ready_i = 1'b0;
    applyStimulus(1'b0, 2'd0, 4'd0, 6'd0, 8'd0, 1'b0);
    tick();
    tick();

    // Reset values
    checkOutput("rst_ready",  64'(req_ready_o), 64'd0);
    checkOutput("rst_valid",  64'(rsp_valid_o), 64'd0);
    checkOutput("rst_orphan", 64'(orphan_w_o),  64'd0);
    checkOutput("rst_last",   64'(rsp_last_o),  64'd0);
    checkOutput("rst_resp",   64'(rsp_resp_o),  64'd0);
    rst_ni = 1'b1;
    #1;
    checkOutput("release_ready", 64'(req_ready_o), 64'd0);
    tick();
    checkOutput("alive_ready", 64'(req_ready_o), 64'd1);

    // AW(id3,src5) + 4 W beats -> one B one cycle after the last W
    rsp_ready_i = 1'b1;
    applyStimulus(1'b1, 2'd0, 4'd3, 6'd5, 8'd0, 1'b0);
    checkOutput("aw_ready", 64'(req_ready_o), 64'd1);
    tick();
    checkOutput("aw_no_rsp", 64'(rsp_valid_o), 64'd0);
    for (int b = 0; b < 4; b++) begin
      applyStimulus(1'b1, 2'd1, 4'd0, 6'd0, 8'd0, (b == 3));
      checkOutput("w_ready", 64'(req_ready_o), 64'd1);
      tick();
      if (b < 3) checkOutput("w_no_rsp", 64'(rsp_valid_o), 64'd0);
    end
    applyStimulus(1'b0, 2'd0, 4'd0, 6'd0, 8'd0, 1'b0);
    checkOutput("b_valid", 64'(rsp_valid_o),  64'd1);
    checkOutput("b_type",  64'(rsp_type_o),   64'd0);
    checkOutput("b_id",    64'(rsp_axi_id_o), 64'd3);
    checkOutput("b_dst",   64'(rsp_dst_id_o), 64'd5);
    checkOutput("b_resp",  64'(rsp_resp_o),   64'd3);
    checkOutput("b_last",  64'(rsp_last_o),   64'd1);
    checkOutput("b_ready", 64'(req_ready_o),  64'd0);
    tick();
    checkOutput("b_done", 64'(rsp_valid_o), 64'd0);

    // AR(id7,src2,len3) with rsp_ready alternating 0/1
    rsp_ready_i = 1'b0;
    applyStimulus(1'b1, 2'd2, 4'd7, 6'd2, 8'd3, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, 4'd0, 6'd0, 8'd0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      checkOutput("r_valid", 64'(rsp_valid_o),  64'd1);
      checkOutput("r_type",  64'(rsp_type_o),   64'd1);
      checkOutput("r_id",    64'(rsp_axi_id_o), 64'd7);
      checkOutput("r_dst",   64'(rsp_dst_id_o), 64'd2);
      checkOutput("r_data",  rsp_data_o,        64'd0);
      checkOutput("r_resp",  64'(rsp_resp_o),   64'd3);
      checkOutput("r_last",  64'(rsp_last_o),   64'(b == 3));
      rsp_ready_i = 1'b0;
      tick();
      checkOutput("r_hold_valid", 64'(rsp_valid_o),  64'd1);
      checkOutput("r_hold_id",    64'(rsp_axi_id_o), 64'd7);
      checkOutput("r_hold_last",  64'(rsp_last_o),   64'(b == 3));
      rsp_ready_i = 1'b1;
      tick();
    end
    checkOutput("r_done_valid", 64'(rsp_valid_o), 64'd0);
    checkOutput("r_done_ready", 64'(req_ready_o),  64'd1);

    // AR len=255 -> 256 beats, next AR accepted the cycle after the final handshake
    applyStimulus(1'b1, 2'd2, 4'd1, 6'd9, 8'd255, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, 4'd0, 6'd0, 8'd0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      checkOutput("long_valid", 64'(rsp_valid_o), 64'd1);
      checkOutput("long_last",  64'(rsp_last_o),  64'(i == 255));
      if (i == 255) begin
        applyStimulus(1'b1, 2'd2, 4'd2, 6'd3, 8'd0, 1'b0);
        checkOutput("long_stall_ready", 64'(req_ready_o), 64'd0);
      end
      tick();
    end
    checkOutput("long_done_valid", 64'(rsp_valid_o), 64'd0);
    checkOutput("long_idle_ready", 64'(req_ready_o), 64'd1);
    tick();
    applyStimulus(1'b0, 2'd0, 4'd0, 6'd0, 8'd0, 1'b0);
    checkOutput("next_ar_valid", 64'(rsp_valid_o),  64'd1);
    checkOutput("next_ar_id",    64'(rsp_axi_id_o), 64'd2);
    checkOutput("next_ar_dst",   64'(rsp_dst_id_o), 64'd3);
    checkOutput("next_ar_last",  64'(rsp_last_o),   64'd1);
    tick();
    checkOutput("next_ar_done", 64'(rsp_valid_o), 64'd0);

    // Orphan W in IDLE and reserved type: both discarded silently
    checkOutput("orphan_clear", 64'(orphan_w_o), 64'd0);
    applyStimulus(1'b1, 2'd1, 4'd0, 6'd0, 8'd0, 1'b1);
    checkOutput("orphan_ready", 64'(req_ready_o), 64'd1);
    tick();
    applyStimulus(1'b0, 2'd0, 4'd0, 6'd0, 8'd0, 1'b0);
    checkOutput("orphan_no_rsp", 64'(rsp_valid_o), 64'd0);
    checkOutput("orphan_set",    64'(orphan_w_o),  64'd1);
    applyStimulus(1'b1, 2'd3, 4'd0, 6'd0, 8'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, 4'd0, 6'd0, 8'd0, 1'b0);
    tick();
    checkOutput("rsvd_no_rsp", 64'(rsp_valid_o), 64'd0);
    checkOutput("rsvd_idle",   64'(req_ready_o), 64'd1);
    checkOutput("orphan_sticky", 64'(orphan_w_o), 64'd1);

    // AW then AR during W_DRAIN: AR stalls until the B handshake, then served
    applyStimulus(1'b1, 2'd0, 4'd10, 6'd33, 8'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd2, 4'd4, 6'd6, 8'd1, 1'b0);
    checkOutput("drain_ar_ready", 64'(req_ready_o), 64'd0);
    tick();
    tick();
    checkOutput("drain_ar_stall", 64'(req_ready_o), 64'd0);
    checkOutput("drain_no_rsp",   64'(rsp_valid_o), 64'd0);
    applyStimulus(1'b1, 2'd1, 4'd0, 6'd0, 8'd0, 1'b1);
    checkOutput("drain_w_ready", 64'(req_ready_o), 64'd1);
    tick();
    rsp_ready_i = 1'b0;
    applyStimulus(1'b1, 2'd2, 4'd4, 6'd6, 8'd1, 1'b0);
    checkOutput("b2_ar_ready", 64'(req_ready_o),  64'd0);
    checkOutput("b2_valid",    64'(rsp_valid_o),  64'd1);
    checkOutput("b2_type",     64'(rsp_type_o),   64'd0);
    checkOutput("b2_id",       64'(rsp_axi_id_o), 64'd10);
    checkOutput("b2_dst",      64'(rsp_dst_id_o), 64'd33);
    tick();
    checkOutput("b2_hold_valid", 64'(rsp_valid_o),  64'd1);
    checkOutput("b2_hold_id",    64'(rsp_axi_id_o), 64'd10);
    checkOutput("b2_hold_ready", 64'(req_ready_o),  64'd0);
    rsp_ready_i = 1'b1;
    tick();
    checkOutput("b2_done",     64'(rsp_valid_o), 64'd0);
    checkOutput("b2_idle_rdy", 64'(req_ready_o), 64'd1);
    tick();
    applyStimulus(1'b0, 2'd0, 4'd0, 6'd0, 8'd0, 1'b0);
    checkOutput("r2_valid", 64'(rsp_valid_o),  64'd1);
    checkOutput("r2_type",  64'(rsp_type_o),   64'd1);
    checkOutput("r2_id",    64'(rsp_axi_id_o), 64'd4);
    checkOutput("r2_dst",   64'(rsp_dst_id_o), 64'd6);
    checkOutput("r2_last0", 64'(rsp_last_o),   64'd0);
    tick();
    checkOutput("r2_last1", 64'(rsp_last_o), 64'd1);
    tick();
    checkOutput("r2_done",        64'(rsp_valid_o), 64'd0);
    checkOutput("orphan_sticky2", 64'(orphan_w_o),  64'd1);

    // Reset during beat 2 of a 4-beat R burst
    applyStimulus(1'b1, 2'd2, 4'd5, 6'd7, 8'd3, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, 4'd0, 6'd0, 8'd0, 1'b0);
    checkOutput("abort_beat1_last", 64'(rsp_last_o), 64'd0);
    tick();
    checkOutput("abort_beat2_valid", 64'(rsp_valid_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    checkOutput("abort_valid",  64'(rsp_valid_o), 64'd0);
    checkOutput("abort_ready",  64'(req_ready_o), 64'd0);
    checkOutput("abort_orphan", 64'(orphan_w_o),  64'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    tick();
    checkOutput("abort_no_resume", 64'(rsp_valid_o), 64'd0);
    checkOutput("abort_idle",      64'(req_ready_o), 64'd1);

`ifdef PB_EJECT_ERR_CNT_EN
    // Three single-beat AR transactions -> count 3, then reset clears it
    checkOutput("cnt_start", 64'(err_cnt_o), 64'd0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 2'd2, 4'(k), 6'(k + 10), 8'd0, 1'b0);
      tick();
      applyStimulus(1'b0, 2'd0, 4'd0, 6'd0, 8'd0, 1'b0);
      tick();
    end
    checkOutput("cnt_three",    64'(err_cnt_o),  64'd3);
    checkOutput("cnt_last_src", 64'(last_src_o), 64'd12);
    rst_ni = 1'b0;
    #1;
    checkOutput("cnt_reset", 64'(err_cnt_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
